// File: rtl/std_sram_arb_pkg.sv
// Shared sizes, state encoding and request bundle for the 64x128 SRAM access controller.
// No logic; types and constants only.
// No flow control of its own.
package std_sram_arb_pkg;

    localparam int SRAM_DEPTH = 64;
    localparam int SRAM_AW    = 6;
    localparam int SRAM_DW    = 128;

    localparam int REQ_A = 0;
    localparam int REQ_B = 1;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } sram_arb_state_t;

    typedef struct packed {
        logic               we;
        logic [SRAM_AW-1:0] addr;
        logic [SRAM_DW-1:0] bwe;
        logic [SRAM_DW-1:0] din;
    } sram_req_t;

endpackage

// File: rtl/std_arb_rr2.sv
// Two-way arbiter: round-robin (FAIR=1) or fixed priority A over B (FAIR=0).
// Latency: grant is combinational from req; last_gnt updates on the accepting edge.
// Backpressure: a requester not granted simply holds req until it is.
module std_arb_rr2
    import std_sram_arb_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    // Holds the index of the most recent winner; B at reset so A wins the first conflict.
    logic last_gnt_q;
    logic last_gnt_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_gnt_q <= 1'(REQ_B);
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            if (FAIR && (last_gnt_q == 1'(REQ_A))) begin
                gnt = 2'b10;
            end else begin
                gnt = 2'b01;
            end
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (accept) begin
            last_gnt_d = gnt[REQ_B];
        end
    end

endmodule

// File: rtl/std_sram_64d128x_arb2.sv
// Two-requester access controller for the 64x128 bit-write SRAM; optional post-reset zero fill (STD_SRAM_ARB_INIT_CLEAR_EN).
// Latency: grant 0 cycles; read data returns one cycle after acceptance.
// Backpressure: requesters hold req until granted; grants stay low during reset and the clear sequence.
module std_sram_64d128x_arb2
    import std_sram_arb_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               a_req,
    input  logic               a_we,
    input  logic [SRAM_AW-1:0] a_addr,
    input  logic [SRAM_DW-1:0] a_bwe,
    input  logic [SRAM_DW-1:0] a_din,
    output logic               a_gnt,
    output logic               a_rvalid,
    output logic [SRAM_DW-1:0] a_rdata,
    input  logic               b_req,
    input  logic               b_we,
    input  logic [SRAM_AW-1:0] b_addr,
    input  logic [SRAM_DW-1:0] b_bwe,
    input  logic [SRAM_DW-1:0] b_din,
    output logic               b_gnt,
    output logic               b_rvalid,
    output logic [SRAM_DW-1:0] b_rdata,
    output logic               sram_en,
    output logic               sram_we,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_bwe,
    output logic [SRAM_DW-1:0] sram_din,
    input  logic [SRAM_DW-1:0] sram_dout,
    output logic               busy
);

    logic               init_act;
    logic [SRAM_AW-1:0] init_addr;
    logic [1:0]         req_vld;
    logic [1:0]         gnt;
    logic               accept;
    sram_req_t          a_cmd;
    sram_req_t          b_cmd;
    sram_req_t          win_cmd;
    logic [1:0]         rd_own_q;
    logic [1:0]         rd_own_d;

`ifdef STD_SRAM_ARB_INIT_CLEAR_EN
    sram_arb_state_t    state_q;
    sram_arb_state_t    state_d;
    logic [SRAM_AW-1:0] clr_addr_q;
    logic [SRAM_AW-1:0] clr_addr_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= INIT;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == INIT) begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == SRAM_AW'(SRAM_DEPTH - 1)) begin
                state_d = RUN;
            end
        end
    end

    // The reset term keeps the SRAM idle while resetn is held low.
    assign init_act  = (state_q == INIT) & resetn;
    assign init_addr = clr_addr_q;
    assign busy      = (state_q == INIT);
`else
    assign init_act  = 1'b0;
    assign init_addr = '0;
    assign busy      = 1'b0;
`endif

    assign a_cmd   = {a_we, a_addr, a_bwe, a_din};
    assign b_cmd   = {b_we, b_addr, b_bwe, b_din};
    assign req_vld = {b_req, a_req} & {2{~busy & resetn}};

    std_arb_rr2 #(
        .FAIR   (FAIR)
    ) u_arb (
        .clk    (clk),
        .resetn (resetn),
        .req    (req_vld),
        .accept (accept),
        .gnt    (gnt)
    );

    assign accept  = |gnt;
    assign a_gnt   = gnt[REQ_A];
    assign b_gnt   = gnt[REQ_B];
    assign win_cmd = gnt[REQ_B] ? b_cmd : a_cmd;

    always_comb begin
        sram_en   = 1'b0;
        sram_we   = 1'b0;
        sram_addr = '0;
        sram_bwe  = '0;
        sram_din  = '0;
        if (init_act) begin
            sram_en   = 1'b1;
            sram_we   = 1'b1;
            sram_addr = init_addr;
            sram_bwe  = '1;
        end else if (accept) begin
            sram_en   = 1'b1;
            sram_we   = win_cmd.we;
            sram_addr = win_cmd.addr;
            sram_bwe  = win_cmd.we ? win_cmd.bwe : '0;
            sram_din  = win_cmd.din;
        end
    end

    assign rd_own_d = (accept & ~win_cmd.we) ? gnt : 2'b00;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_own_q <= 2'b00;
        end else begin
            rd_own_q <= rd_own_d;
        end
    end

    // Read data comes straight off the macro; only the owner flag is registered.
    assign a_rvalid = rd_own_q[REQ_A];
    assign b_rvalid = rd_own_q[REQ_B];
    assign a_rdata  = sram_dout;
    assign b_rdata  = sram_dout;

endmodule
